// File: rtl/i2c_mon_pkg.sv
// Shared types and constants for the passive I2C bus monitor.
package i2c_mon_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = $clog2(BYTE_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        BITS,
        ACK
    } i2c_mon_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus stability filter for one open-drain I2C line; resets to the idle level (1).
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic [CNT_W-1:0]       cnt_q,  cnt_d;

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
        filt_d = filt_q;
        cnt_d  = '0;
        // A differing level must persist FILT_LEN cycles; any return to filt_q restarts the count.
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C observer: START/rep-START/STOP detection and byte+ACK capture.
// Define I2C_MON_TIMEOUT_EN to enable the SCL-low timeout; otherwise timeout_o is tied low.
module i2c_bus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              bus_busy_o,
    output logic              start_o,
    output logic              rep_start_o,
    output logic              stop_o,
    output logic              byte_valid_o,
    output logic [BYTE_W-1:0] byte_o,
    output logic              ack_o,
    output logic              first_o,
    output logic              frag_err_o,
    output logic              timeout_o
);

    logic scl_f, sda_f, scl_p_q, sda_p_q;
    logic scl_rise, scl_edge, sda_rise, sda_fall, start_c, stop_c, tmo_fire;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .rst(rst), .line_i(scl_i), .line_o(scl_f));
    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .rst(rst), .line_i(sda_i), .line_o(sda_f));

    assign scl_rise = scl_f & ~scl_p_q;
    assign scl_edge = scl_f ^ scl_p_q;
    assign sda_rise = sda_f & ~sda_p_q;
    assign sda_fall = ~sda_f & sda_p_q;
    // An SDA edge coinciding with an SCL edge is data movement, never a bus condition.
    assign start_c  = sda_fall & scl_f & ~scl_edge;
    assign stop_c   = sda_rise & scl_f & ~scl_edge;

    i2c_mon_state_e       state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]    shreg_q, shreg_d, byte_q, byte_d;
    logic first_q, first_d, busy_q, busy_d;
    logic start_q, start_d, rep_start_q, rep_start_d, stop_q, stop_d;
    logic byte_valid_q, byte_valid_d, ack_q, ack_d, first_out_q, first_out_d;
    logic frag_err_q, frag_err_d, timeout_q, timeout_d;

`ifdef I2C_MON_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = '0;
        tmo_fire  = 1'b0;
        if (busy_q && !scl_f && state_q != IDLE) begin
            if (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYC)) begin
                tmo_fire = 1'b1;
            end else if (tmo_cnt_q != '1) begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^{TIMEOUT_W, TIMEOUT_CYC};
    assign tmo_fire       = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        first_d      = first_q;
        busy_d       = busy_q;
        byte_d       = byte_q;
        ack_d        = ack_q;
        first_out_d  = first_out_q;
        start_d      = 1'b0;
        rep_start_d  = 1'b0;
        stop_d       = 1'b0;
        byte_valid_d = 1'b0;
        frag_err_d   = 1'b0;
        timeout_d    = 1'b0;
        if (stop_c) begin
            stop_d     = 1'b1;
            frag_err_d = (bit_cnt_q != '0);
            state_d    = IDLE;
            bit_cnt_d  = '0;
            busy_d     = 1'b0;
        end else if (start_c) begin
            start_d     = (state_q == IDLE);
            rep_start_d = (state_q != IDLE);
            frag_err_d  = (bit_cnt_q != '0);
            state_d     = BITS;
            bit_cnt_d   = '0;
            first_d     = 1'b1;
            busy_d      = 1'b1;
        end else if (tmo_fire) begin
            timeout_d  = 1'b1;
            frag_err_d = (bit_cnt_q != '0);
            state_d    = IDLE;
            bit_cnt_d  = '0;
            busy_d     = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                BITS: begin
                    shreg_d   = {shreg_q[BYTE_W-2:0], sda_f};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) state_d = ACK;
                end
                ACK: begin
                    byte_valid_d = 1'b1;
                    byte_d       = shreg_q;
                    ack_d        = ~sda_f;
                    first_out_d  = first_q;
                    first_d      = 1'b0;
                    bit_cnt_d    = '0;
                    state_d      = BITS;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p_q      <= 1'b1;
            sda_p_q      <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            first_q      <= 1'b0;
            busy_q       <= 1'b0;
            byte_q       <= '0;
            ack_q        <= 1'b0;
            first_out_q  <= 1'b0;
            start_q      <= 1'b0;
            rep_start_q  <= 1'b0;
            stop_q       <= 1'b0;
            byte_valid_q <= 1'b0;
            frag_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            scl_p_q      <= scl_f;
            sda_p_q      <= sda_f;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            first_q      <= first_d;
            busy_q       <= busy_d;
            byte_q       <= byte_d;
            ack_q        <= ack_d;
            first_out_q  <= first_out_d;
            start_q      <= start_d;
            rep_start_q  <= rep_start_d;
            stop_q       <= stop_d;
            byte_valid_q <= byte_valid_d;
            frag_err_q   <= frag_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus_busy_o   = busy_q;
    assign start_o      = start_q;
    assign rep_start_o  = rep_start_q;
    assign stop_o       = stop_q;
    assign byte_valid_o = byte_valid_q;
    assign byte_o       = byte_q;
    assign ack_o        = ack_q;
    assign first_o      = first_out_q;
    assign frag_err_o   = frag_err_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Scoreboard bench for i2c_bus_monitor: pin-level I2C stimulus, transaction-level expected events.
module tb_i2c_bus_monitor;

    typedef struct packed {
        logic       start;
        logic       rep;
        logic       stop;
        logic       bval;
        logic       frag;
        logic       tmo;
        logic [7:0] data;
        logic       ack;
        logic       first;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic       bus_busy_o, start_o, rep_start_o, stop_o, byte_valid_o;
    logic [7:0] byte_o;
    logic       ack_o, first_o, frag_err_o, timeout_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   phase   = 20;
    int   last_start_cyc = -1;
    int   n_tmo   = 0;
    ev_t  exp_q[$];
    logic m_in_txn = 1'b0;
    logic m_first  = 1'b0;
    logic m_bits[$];

    i2c_bus_monitor #(
        .SYNC_STAGES(2), .FILT_LEN(3), .TIMEOUT_W(16), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda),
        .bus_busy_o(bus_busy_o), .start_o(start_o), .rep_start_o(rep_start_o),
        .stop_o(stop_o), .byte_valid_o(byte_valid_o), .byte_o(byte_o), .ack_o(ack_o),
        .first_o(first_o), .frag_err_o(frag_err_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (tests=%0d failed=%0d)", n_tests, n_fail);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse is one observed event, compared in order with the model.
    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        if (start_o | rep_start_o | stop_o | byte_valid_o | frag_err_o | timeout_o) begin
            act       = '0;
            act.start = start_o;
            act.rep   = rep_start_o;
            act.stop  = stop_o;
            act.bval  = byte_valid_o;
            act.frag  = frag_err_o;
            act.tmo   = timeout_o;
            if (byte_valid_o) begin
                act.data  = byte_o;
                act.ack   = ack_o;
                act.first = first_o;
            end
            if (start_o) last_start_cyc = cyc;
            if (timeout_o) n_tmo++;
            if (rep_start_o) check("busy_at_rep_start", 32'(bus_busy_o), 1);
            check("event_was_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("event", 32'(act), 32'(e));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a byte is complete after nine SCL rises inside a transaction.
    task automatic model_rise(input logic b);
        ev_t e;
        if (m_in_txn) begin
            m_bits.push_back(b);
            if (m_bits.size() == 9) begin
                e = '0;
                e.bval = 1'b1;
                for (int i = 0; i < 8; i++) e.data[7-i] = m_bits[i];
                e.ack   = !m_bits[8];
                e.first = m_first;
                exp_q.push_back(e);
                m_first = 1'b0;
                m_bits.delete();
            end
        end
    endtask

    task automatic push_cond(input logic is_start);
        ev_t e;
        e = '0;
        e.frag = m_in_txn && (m_bits.size() != 0);
        if (is_start) begin
            e.start  = !m_in_txn;
            e.rep    = m_in_txn;
            m_in_txn = 1'b1;
            m_first  = 1'b1;
        end else begin
            e.stop   = 1'b1;
            m_in_txn = 1'b0;
        end
        m_bits.delete();
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_in_txn = 1'b0;
        m_first  = 1'b0;
        m_bits.delete();
    endtask

    task automatic set_scl(input logic v);
        if (v && !scl) model_rise(sda);
        scl = v;
        wait_clk(phase);
    endtask

    task automatic set_sda(input logic v);
        sda = v;
        wait_clk(phase);
    endtask

    task automatic i2c_start();
        set_sda(1'b1);
        set_scl(1'b1);
        push_cond(1'b1);
        set_sda(1'b0);
        set_scl(1'b0);
    endtask

    task automatic i2c_stop();
        set_sda(1'b0);
        set_scl(1'b1);
        push_cond(1'b0);
        set_sda(1'b1);
    endtask

    task automatic send_bit(input logic b);
        set_sda(b);
        set_scl(1'b1);
        set_scl(1'b0);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(!ack);
    endtask

    task automatic drain(input string name);
        wait_clk(30);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 0);
    endtask

    function automatic logic [16:0] all_outputs();
        return {bus_busy_o, start_o, rep_start_o, stop_o, byte_valid_o, byte_o,
                ack_o, first_o, frag_err_o, timeout_o};
    endfunction

    initial begin
        int t0;
        int start_before;
        int nbytes;
        int tmo_before;

        wait_clk(5);
        check("reset_outputs", 32'(all_outputs()), 0);
        rst = 1'b0;
        wait_clk(10);
        check("idle_after_reset", 32'(all_outputs()), 0);

        // Write 0xA4 ACK, 0x3C NACK, STOP.
        i2c_start();
        check("busy_after_start", 32'(bus_busy_o), 1);
        send_byte(8'hA4, 1'b1);
        send_byte(8'h3C, 1'b0);
        i2c_stop();
        drain("write");
        check("busy_after_stop", 32'(bus_busy_o), 0);

        // Repeated START between two bytes.
        i2c_start();
        send_byte(8'hA5, 1'b1);
        i2c_start();
        check("busy_after_rep_start", 32'(bus_busy_o), 1);
        send_byte(8'hB6, 1'b1);
        i2c_stop();
        drain("rep_start");

        // 2-cycle SDA glitch with SCL high is dropped; 3 cycles is accepted as START.
        start_before = last_start_cyc;
        sda = 1'b0;
        wait_clk(2);
        sda = 1'b1;
        wait_clk(30);
        check("glitch_no_start", 32'(last_start_cyc), 32'(start_before));
        check("glitch_no_event", 32'(exp_q.size()), 0);
        push_cond(1'b1);
        sda = 1'b0;
        t0  = cyc;
        wait_clk(phase);
        check("start_latency", 32'(last_start_cyc - t0), 6);
        set_scl(1'b0);
        send_byte(8'h5A, 1'b0);
        i2c_stop();
        drain("filter");

        // STOP after four data bits.
        i2c_start();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        i2c_stop();
        drain("frag_stop");

        // Reset mid-byte: everything clears, remaining bits are ignored until the next START.
        i2c_start();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        drain("pre_reset");
        rst = 1'b1;
        wait_clk(3);
        check("mid_reset_outputs", 32'(all_outputs()), 0);
        model_reset();
        rst = 1'b0;
        wait_clk(10);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        send_byte(8'($urandom), 1'b1);
        check("busy_after_reset_bits", 32'(bus_busy_o), 0);
        i2c_stop();
        drain("post_reset");

        // Randomised transactions: 1..3 bytes, optional partial byte, STOP or repeated START.
        for (int t = 0; t < 12; t++) begin
            phase = $urandom_range(8, 20);
            i2c_start();
            nbytes = $urandom_range(1, 3);
            for (int b = 0; b < nbytes; b++) send_byte(8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 7)); i++) send_bit(1'($urandom_range(0, 1)));
            end
            if (t == 11 || $urandom_range(0, 2) != 0) begin
                i2c_stop();
            end
        end
        drain("random");
        check("busy_after_random", 32'(bus_busy_o), 0);

        // SCL held low well beyond TIMEOUT_CYC after START.
        phase = 20;
        tmo_before = n_tmo;
        i2c_start();
`ifdef I2C_MON_TIMEOUT_EN
        begin
            ev_t e;
            e = '0;
            e.tmo = 1'b1;
            e.frag = (m_bits.size() != 0);
            exp_q.push_back(e);
            model_reset();
        end
`endif
        wait_clk(300);
`ifdef I2C_MON_TIMEOUT_EN
        check("timeout_pulses", 32'(n_tmo - tmo_before), 1);
        check("busy_after_timeout", 32'(bus_busy_o), 0);
`else
        check("timeout_pulses", 32'(n_tmo - tmo_before), 0);
        check("busy_without_timeout", 32'(bus_busy_o), 1);
`endif
        i2c_stop();
        drain("timeout");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
